// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU run-control / trace-capture block.
package cpu_trace_pkg;

    // Encoding of the 2-bit mode input.
    localparam logic [1:0] ModeEncHalt  = 2'b00;
    localparam logic [1:0] ModeEncRun   = 2'b01;
    localparam logic [1:0] ModeEncStep  = 2'b10;
    localparam logic [1:0] ModeEncRunBp = 2'b11;

    typedef enum logic [1:0] {
        ModeHalt  = ModeEncHalt,
        ModeRun   = ModeEncRun,
        ModeStep  = ModeEncStep,
        ModeRunBp = ModeEncRunBp
    } mode_t;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StBpRun,
        StDrain
    } state_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer; when full, a lone write overwrites the oldest entry.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;

    logic full, empty, do_rd, do_ovw;

    assign full   = (count_q == FullCount);
    assign empty  = (count_q == '0);
    assign do_rd  = rd_en && !empty;
    // Coincident read frees the oldest slot, so only a lone write overwrites.
    assign do_ovw = wr_en && full && !do_rd;

    // Storage array; no reset needed, occupancy comes from the pointers.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy, sticky overflow and registered read port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_rd || do_ovw) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (wr_en && !do_rd && !full) begin
                count_q <= count_q + CntW'(1);
            end else if (do_rd && !wr_en) begin
                count_q <= count_q - CntW'(1);
            end
            // Overwrite wins over a clear in the same cycle.
            if (do_ovw) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
            rd_valid_q <= do_rd;
            if (do_rd) begin
                rd_data_q <= mem_q[rptr_q];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/cpu_step_tracer.sv
// Run-control (halt / run / N-step / run-to-breakpoint) and trace capture for a single-cycle CPU.
module cpu_step_tracer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [1:0]               mode,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         step_count,
    input  logic [ADDR_W-1:0]        bp_addr,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_result,
    output logic                     cpu_en,
    input  logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_result,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         cycles
);

    localparam int unsigned EntryW = ADDR_W + DATA_W;

    state_t             state_q;
    logic [CNT_W-1:0]   step_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cycles_q;
    logic               cap_pend_q;
    logic               cpu_en_c;
    logic               start_ok;
    logic               bp_hit;
    logic [EntryW-1:0]  rd_data;

    assign bp_hit   = (cpu_addr == bp_addr);
    assign start_ok = (state_q == StIdle) && start && !stop;

    // Clock-enable is combinational so a breakpoint match or stop gates it in the same cycle.
    always_comb begin
        cpu_en_c = 1'b0;
        if (!stop) begin
            case (state_q)
                StRun:   cpu_en_c = 1'b1;
                StStep:  cpu_en_c = (step_cnt_q != '0);
                StBpRun: cpu_en_c = !bp_hit;
                default: cpu_en_c = 1'b0;
            endcase
        end
    end

    assign cpu_en = cpu_en_c;

    // Run-control FSM with registered busy/done.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            case (mode_t'(mode))
                                ModeRun: begin
                                    state_q <= StRun;
                                    busy_q  <= 1'b1;
                                end
                                ModeStep: begin
                                    // Zero steps skips straight to the drain cycle.
                                    state_q    <= (step_count == '0) ? StDrain : StStep;
                                    step_cnt_q <= step_count;
                                    busy_q     <= 1'b1;
                                end
                                ModeRunBp: begin
                                    state_q <= StBpRun;
                                    busy_q  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    StRun: ;
                    StStep: begin
                        if (step_cnt_q != '0) begin
                            step_cnt_q <= step_cnt_q - CNT_W'(1);
                        end
                        if (step_cnt_q <= CNT_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                    StBpRun: begin
                        if (bp_hit) begin
                            state_q <= StDrain;
                        end
                    end
                    StDrain: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating enable-pulse counter and capture-pending flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cycles_q   <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            cap_pend_q <= cpu_en_c;
            if (start_ok) begin
                cycles_q <= '0;
            end else if (cpu_en_c && (cycles_q != '1)) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
        end
    end

    // Capture the CPU's post-advance state one cycle after each enable pulse.
    trace_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .wr_en    (cap_pend_q),
        .wr_data  ({cpu_addr, cpu_result}),
        .rd_en    (rd_en),
        .clr_ovf  (start_ok),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow)
    );

    assign rd_addr   = rd_data[EntryW-1:DATA_W];
    assign rd_result = rd_data[DATA_W-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_step_tracer.sv
// Directed + randomized bench for cpu_step_tracer with a queue-based trace model.
module tb_cpu_step_tracer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [1:0]        mode = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [CNT_W-1:0]  step_count = '0;
    logic [ADDR_W-1:0] bp_addr = '0;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_result;
    logic              cpu_en;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_result;
    logic              rd_valid;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycles;

    logic              cpu_load = 1'b0;
    logic [ADDR_W-1:0] cpu_load_val = '0;
    logic [31:0]       salt = 32'h0;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    logic [63:0] q[$];
    bit          m_ovf = 1'b0;

    always #5 Clock = ~Clock;

    cpu_step_tracer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .mode       (mode),
        .start      (start),
        .stop       (stop),
        .step_count (step_count),
        .bp_addr    (bp_addr),
        .cpu_addr   (cpu_addr),
        .cpu_result (cpu_result),
        .cpu_en     (cpu_en),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_result  (rd_result),
        .rd_valid   (rd_valid),
        .count      (count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done),
        .cycles     (cycles)
    );

    // Stand-in CPU: each enabled edge advances addr by 4; result is a hash of addr.
    always @(posedge Clock) begin
        if (cpu_load) cpu_addr <= cpu_load_val;
        else if (cpu_en) cpu_addr <= cpu_addr + 32'd4;
    end
    assign cpu_result = (cpu_addr * 32'h9E3779B1) ^ salt;

    always @(posedge Clock) begin
        if (cpu_en) pulses <= pulses + 1;
    end

    function automatic logic [31:0] res_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] a);
        if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
        end
        q.push_back({a, res_of(a)});
    endtask

    task automatic load_addr(input logic [31:0] a);
        cpu_load = 1'b1;
        cpu_load_val = a;
        tick;
        cpu_load = 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input int n);
        mode = m;
        step_count = CNT_W'(n);
        start = 1'b1;
        tick;
        start = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            tick;
            lat++;
        end
        check("done_seen", 64'(done), 64'(1));
    endtask

    task automatic post_run(input string tag, input logic [31:0] a, input int n, input int p0);
        check({tag, "_pulses"}, 64'(pulses - p0), 64'(n));
        check({tag, "_cycles"}, 64'(cycles), 64'(n));
        check({tag, "_cpu_addr"}, 64'(cpu_addr), 64'(a + 32'(4 * n)));
        for (int i = 1; i <= n; i++) model_push(a + 32'(4 * i));
        check({tag, "_count"}, 64'(count), 64'(q.size()));
        check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        tick;
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    task automatic run_step(input int n, input string tag);
        logic [31:0] a;
        int p0, lat;
        a = cpu_addr;
        p0 = pulses;
        launch(2'b10, n);
        wait_done(n + 10, lat);
        check({tag, "_lat"}, 64'(lat), 64'(n + 2));
        post_run(tag, a, n, p0);
    endtask

    task automatic run_bp(input int m, input string tag);
        logic [31:0] a;
        int p0, lat;
        a = cpu_addr;
        p0 = pulses;
        bp_addr = a + 32'(4 * m);
        launch(2'b11, 0);
        wait_done(m + 10, lat);
        post_run(tag, a, m, p0);
    endtask

    task automatic read_k(input int k, input string tag);
        logic [63:0] exp;
        for (int i = 0; i < k; i++) begin
            if (q.size() == 0) break;
            rd_en = 1'b1;
            tick;
            rd_en = 1'b0;
            exp = q.pop_front();
            check({tag, "_rd_valid"}, 64'(rd_valid), 64'(1));
            check({tag, "_rd_entry"}, {rd_addr, rd_result}, exp);
            check({tag, "_rd_count"}, 64'(count), 64'(q.size()));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_en"}, 64'(cpu_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
        check({tag, "_rd_result"}, 64'(rd_result), 64'(0));
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_cycles"}, 64'(cycles), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        int p0;
        logic [31:0] a;

        salt = $urandom;
        cpu_load = 1'b1;
        cpu_load_val = 32'h0;
        tick;
        tick;
        cpu_load = 1'b0;
        check_reset_vals("reset");
        Reset = 1'b1;
        tick;

        // STEP 5 and STEP 0, then read back in order.
        run_step(5, "step5");
        run_step(0, "step0");
        read_k(5, "rd_step5");

        // Read from empty buffer is ignored.
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check("rd_empty_valid", 64'(rd_valid), 64'(0));
        check("rd_empty_count", 64'(count), 64'(0));

        // Run to breakpoint 0x20 from address 0.
        load_addr(32'h0);
        run_bp(8, "bp20");
        check("bp20_halt_addr", 64'(cpu_addr), 64'h20);
        read_k(DEPTH, "rd_bp20");

        // Randomized runs with partial readback.
        for (int r = 0; r < 8; r++) begin
            load_addr($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 1) == 1) run_step(int'($urandom_range(1, 12)), "rnd_step");
            else run_bp(int'($urandom_range(1, 12)), "rnd_bp");
            read_k(int'($urandom_range(0, q.size())), "rnd_rd");
        end
        read_k(DEPTH, "rnd_flush");

        // STEP 20 into a 16-deep buffer overflows.
        load_addr(32'h0);
        run_step(20, "step20");

        // Full buffer: read coincident with the capture of a single step.
        a = cpu_addr;
        launch(2'b10, 1);
        tick;
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        exp = q.pop_front();
        check("coin_rd_valid", 64'(rd_valid), 64'(1));
        check("coin_rd_addr", 64'(rd_addr), 64'h14);
        check("coin_rd_entry", {rd_addr, rd_result}, exp);
        model_push(a + 32'd4);
        check("coin_count", 64'(count), 64'(DEPTH));
        check("coin_overflow", 64'(overflow), 64'(0));
        check("coin_done", 64'(done), 64'(1));
        read_k(DEPTH, "rd_coin");

        // RUN, then stop after three pulses.
        a = cpu_addr;
        p0 = pulses;
        launch(2'b01, 0);
        tick;
        tick;
        tick;
        stop = 1'b1;
        #1;
        check("stop_cpu_en", 64'(cpu_en), 64'(0));
        check("stop_pulses", 64'(pulses - p0), 64'(3));
        tick;
        stop = 1'b0;
        check("stop_busy", 64'(busy), 64'(0));
        check("stop_count", 64'(count), 64'(3));
        for (int i = 1; i <= 3; i++) model_push(a + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            check("stop_no_done", 64'(done), 64'(0));
            tick;
        end
        read_k(2, "rd_stop");

        // Asynchronous reset in the middle of a run.
        launch(2'b01, 0);
        tick;
        #2;
        check("pre_rst_cpu_en", 64'(cpu_en), 64'(1));
        Reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        q.delete();
        tick;
        Reset = 1'b1;
        tick;
        check("post_rst_busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
